mac_mii_tx_top: RTL and testbench

Ethernet MAC transmit framer feeding a 64-bit XGMII-style MII. On request it builds a full frame from its field inputs and serialises it 8 bytes per clock, with control-character framing and inter-packet idles:
- frame = preamble, SFD, destination, source, EtherType, payload, pad, FCS
- framing = Start, Terminate, Idle, Error control characters

It sits between the packet source and the PCS encoder and drives the MII/MAC checkers in verification.

---
 rtl/mac_mii_tx_top.sv | 188 ++++++++++++++++++
 tb/tb_mac_mii_tx_top.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_mii_tx_top.sv
// Ethernet MAC transmit framer onto a 64-bit XGMII-style MII.
// Latches a frame, streams 8 bytes/clock with a byte-parallel CRC-32.
module mac_mii_tx_top #(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int PAYLOAD_LENGTH   = 32
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [47:0] i_dest_address,
  input  logic [47:0] i_src_address,
  input  logic [15:0] i_eth_type,
  input  logic [15:0] i_payload_length,
  input  logic [7:0]  i_payload [PAYLOAD_LENGTH],
  input  logic [7:0]  i_interrupt,
  output logic        o_txValid,
  output logic [63:0] o_mii_data,
  output logic [7:0]  o_mii_valid
);

  localparam int LEN_CAP =
    (PAYLOAD_LENGTH < PAYLOAD_MAX_SIZE) ? PAYLOAD_LENGTH : PAYLOAD_MAX_SIZE;
  localparam int BUF_LEN = 14 + ((LEN_CAP > 46) ? LEN_CAP : 46);
  localparam int AW      = $clog2(BUF_LEN);
  localparam int DEPTH   = 1 << AW;
  localparam logic [15:0] CAP16   = 16'(LEN_CAP);
  localparam logic [63:0] IDLE_COL = {8{8'h07}};
  localparam logic [63:0] SOF_COL  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_COL = {{7{8'h07}}, 8'hFD};

  typedef enum logic [2:0] {IDLE, SOF, DATA, TERM, IPG} state_t;

  state_t      state;
  logic [7:0]  frame [DEPTH];
  logic [7:0]  lat   [DEPTH];
  logic [15:0] pos, data_end, len, end_next, lp;
  logic [31:0] crc, crc_next, fcs;
  logic [63:0] col_data;
  logic [7:0]  col_ctrl;
  logic [1:0]  off;
  logic        abort, fcs_inv, gap, take, col_term, pad;
  logic        unused_bits;

  assign unused_bits = ^i_interrupt[7:3];

  assign len = (i_payload_length > CAP16) ? CAP16 : i_payload_length;
  assign pad = (len < 16'd46) && !i_interrupt[0];
  assign end_next = 16'd14 + (pad ? 16'd46 : len);
  assign take = i_start && (state == IDLE || (state == IPG && gap));

  // Header + payload image; bytes past len read as zero, which is the pad.
  for (genvar g = 0; g < DEPTH; g++) begin : g_lat
    if (g < 6) begin : g_d
      assign lat[g] = i_dest_address[47-8*g -: 8];
    end else if (g < 12) begin : g_s
      assign lat[g] = i_src_address[47-8*(g-6) -: 8];
    end else if (g < 14) begin : g_t
      assign lat[g] = i_eth_type[15-8*(g-12) -: 8];
    end else if (g - 14 < PAYLOAD_LENGTH) begin : g_p
      assign lat[g] = (16'(g - 14) < len) ? i_payload[g-14] : 8'h00;
    end else begin : g_z
      assign lat[g] = 8'h00;
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FCS lanes use crc_next so a column may hold the last data and the FCS.
  always_comb begin
    crc_next = crc;
    col_data = IDLE_COL;
    col_ctrl = 8'hFF;
    col_term = 1'b0;
    lp       = pos;
    off      = 2'd0;
    fcs      = 32'h0;
    for (int l = 0; l < 8; l++) begin
      lp = pos + 16'(l);
      if (!abort && lp < data_end)
        crc_next = crc_byte(crc_next, frame[lp[AW-1:0]]);
    end
    fcs = fcs_inv ? crc_next : ~crc_next;
    for (int l = 0; l < 8; l++) begin
      lp  = pos + 16'(l);
      off = 2'(lp - data_end);
      if (abort) begin
        if (lp < 16'd14) begin
          col_data[8*l +: 8] = frame[lp[AW-1:0]];
          col_ctrl[l] = 1'b0;
        end else begin
          col_data[8*l +: 8] = 8'hFE;
        end
      end else if (lp < data_end) begin
        col_data[8*l +: 8] = frame[lp[AW-1:0]];
        col_ctrl[l] = 1'b0;
      end else if (lp < data_end + 16'd4) begin
        col_data[8*l +: 8] = fcs[{off, 3'b000} +: 8];
        col_ctrl[l] = 1'b0;
      end else if (lp == data_end + 16'd4) begin
        col_data[8*l +: 8] = 8'hFD;
        col_term = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) frame[i] <= 8'h00;
    end else if (take) begin
      frame <= lat;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_mii_data  <= IDLE_COL;
      o_mii_valid <= 8'hFF;
      o_txValid   <= 1'b0;
      pos         <= 16'd0;
      crc         <= 32'hFFFFFFFF;
      data_end    <= 16'd0;
      abort       <= 1'b0;
      fcs_inv     <= 1'b0;
      gap         <= 1'b0;
    end else begin
      if (take) begin
        data_end <= end_next;
        abort    <= i_interrupt[1];
        fcs_inv  <= i_interrupt[2];
      end
      unique case (state)
        IDLE: begin
          o_mii_data  <= IDLE_COL;
          o_mii_valid <= 8'hFF;
          o_txValid   <= 1'b0;
          if (take) state <= SOF;
        end
        SOF: begin
          o_mii_data  <= SOF_COL;
          o_mii_valid <= 8'h01;
          o_txValid   <= 1'b1;
          pos         <= 16'd0;
          crc         <= 32'hFFFFFFFF;
          state       <= DATA;
        end
        DATA: begin
          o_mii_data  <= col_data;
          o_mii_valid <= col_ctrl;
          o_txValid   <= 1'b1;
          crc         <= crc_next;
          pos         <= pos + 16'd8;
          gap         <= 1'b0;
          if (abort) begin
            if (pos >= 16'd14) state <= TERM;
          end else if (col_term) begin
            state <= IPG;
          end else if (pos + 16'd8 == data_end + 16'd4) begin
            state <= TERM;
          end
        end
        TERM: begin
          o_mii_data  <= TERM_COL;
          o_mii_valid <= 8'hFF;
          o_txValid   <= 1'b1;
          gap         <= 1'b0;
          state       <= IPG;
        end
        IPG: begin
          o_mii_data  <= IDLE_COL;
          o_mii_valid <= 8'hFF;
          o_txValid   <= 1'b0;
          gap         <= 1'b1;
          if (gap) state <= take ? SOF : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mii_tx_top.sv
// Bench for mac_mii_tx_top: random frames against a byte-stream
// reference model (frame bytes, CRC-32, lane packing).
module tb_mac_mii_tx_top;

  localparam int PL = 32;
  localparam logic [63:0] IDLE_COL = {8{8'h07}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [47:0] dest, src;
  logic [15:0] etype, plen;
  logic [7:0]  pay [PL];
  logic [7:0]  intr;
  logic        txv;
  logic [63:0] mdata;
  logic [7:0]  mvalid;

  int vecs = 0;
  int errs = 0;

  logic [63:0] got_d[$], exp_d[$];
  logic [7:0]  got_c[$], exp_c[$];

  always #5 clk = ~clk;

  mac_mii_tx_top #(.PAYLOAD_MAX_SIZE(1500), .PAYLOAD_LENGTH(PL)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_dest_address(dest), .i_src_address(src), .i_eth_type(etype),
    .i_payload_length(plen), .i_payload(pay), .i_interrupt(intr),
    .o_txValid(txv), .o_mii_data(mdata), .o_mii_valid(mvalid)
  );

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected frame as a lane stream, then packed 8 lanes per column.
  task automatic build_exp();
    logic [7:0]  b[$];
    logic [7:0]  lb[$];
    bit          lc[$];
    logic [31:0] f;
    logic [63:0] d;
    logic [7:0]  c;
    int          len;
    exp_d = {};
    exp_c = {};
    len = (plen > 16'(PL)) ? PL : int'(plen);
    for (int i = 0; i < 6; i++) b.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
    b.push_back(etype[15:8]);
    b.push_back(etype[7:0]);
    for (int i = 0; i < len; i++) b.push_back(pay[i]);
    lb.push_back(8'hFB); lc.push_back(1'b1);
    for (int i = 0; i < 6; i++) begin lb.push_back(8'h55); lc.push_back(1'b0); end
    lb.push_back(8'hD5); lc.push_back(1'b0);
    if (intr[1]) begin
      for (int i = 0; i < 14; i++) begin lb.push_back(b[i]); lc.push_back(1'b0); end
      while (lb.size() % 8 != 0) begin lb.push_back(8'hFE); lc.push_back(1'b1); end
      for (int i = 0; i < 8; i++) begin lb.push_back(8'hFE); lc.push_back(1'b1); end
    end else begin
      if (!intr[0]) while (b.size() < 60) b.push_back(8'h00);
      f = crc32(b);
      if (intr[2]) f = ~f;
      for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
      foreach (b[i]) begin lb.push_back(b[i]); lc.push_back(1'b0); end
    end
    lb.push_back(8'hFD); lc.push_back(1'b1);
    while (lb.size() % 8 != 0) begin lb.push_back(8'h07); lc.push_back(1'b1); end
    for (int k = 0; k < lb.size() / 8; k++) begin
      d = 64'h0;
      c = 8'h0;
      for (int l = 0; l < 8; l++) begin
        d[8*l +: 8] = lb[8*k + l];
        c[l] = lc[8*k + l];
      end
      exp_d.push_back(d);
      exp_c.push_back(c);
    end
  endtask

  task automatic set_nominal();
    logic [7:0] pat [5];
    pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    dest  = 48'hFFFFFFFFFFFF;
    src   = 48'h123456789ABC;
    etype = 16'h0800;
    plen  = 16'd32;
    intr  = 8'h00;
    for (int i = 0; i < PL; i++) pay[i] = pat[i % 5];
  endtask

  task automatic set_random();
    dest  = {16'($urandom), $urandom};
    src   = {16'($urandom), $urandom};
    etype = 16'($urandom);
    plen  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
    intr  = 8'($urandom);
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
  endtask

  // Monitor: counts idle columns up to the next frame, then records it.
  task automatic capture(input bit drop, output int gap,
                         output bit to, output bit idle_ok);
    int n;
    gap = 0;
    to = 1'b0;
    idle_ok = 1'b1;
    got_d = {};
    got_c = {};
    while (txv !== 1'b1) begin
      if (gap >= 400) begin to = 1'b1; return; end
      if (mdata !== IDLE_COL || mvalid !== 8'hFF) idle_ok = 1'b0;
      gap++;
      @(negedge clk);
    end
    n = 0;
    while (txv === 1'b1) begin
      if (n >= 400) begin to = 1'b1; return; end
      got_d.push_back(mdata);
      got_c.push_back(mvalid);
      n++;
      if (drop) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    vecs++;
    if (mdata !== IDLE_COL) begin
      errs++; $display("FAIL reset_data: got %h want %h", mdata, IDLE_COL);
    end
    vecs++;
    if (mvalid !== 8'hFF) begin
      errs++; $display("FAIL reset_ctrl: got %h want ff", mvalid);
    end
    vecs++;
    if (txv !== 1'b0) begin
      errs++; $display("FAIL reset_txvalid: got %b want 0", txv);
    end
  endtask

  task automatic test_nominal();
    int gap;
    bit to, ok;
    set_nominal();
    build_exp();
    start = 1'b1;
    capture(1'b1, gap, to, ok);
    vecs++;
    if (to) begin errs++; $display("FAIL nominal_timeout: got timeout want frame"); end
    vecs++;
    if (gap != 2) begin errs++; $display("FAIL nominal_latency: got %0d want 2", gap); end
    vecs++;
    if (got_d.size() != 10) begin
      errs++; $display("FAIL nominal_cols: got %0d want 10", got_d.size());
    end else begin
      vecs++;
      if (got_d[0] !== 64'hD5555555555555FB || got_c[0] !== 8'h01) begin
        errs++; $display("FAIL nominal_sof: got %h/%h want d5555555555555fb/01", got_d[0], got_c[0]);
      end
      vecs++;
      if (got_d[1] !== 64'h3412FFFFFFFFFFFF || got_c[1] !== 8'h00) begin
        errs++; $display("FAIL nominal_col1: got %h/%h want 3412ffffffffffff/00", got_d[1], got_c[1]);
      end
      vecs++;
      if (got_d[9] !== 64'h07070707070707FD || got_c[9] !== 8'hFF) begin
        errs++; $display("FAIL nominal_term: got %h/%h want 07070707070707fd/ff", got_d[9], got_c[9]);
      end
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      vecs++;
      if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
        errs++;
        $display("FAIL nominal col%0d: got %h/%h want %h/%h", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_variants();
    logic [7:0] modes [3];
    int         ncol  [3];
    int gap;
    bit to, ok;
    modes = '{8'h01, 8'h04, 8'h02};
    ncol  = '{8, 10, 5};
    for (int m = 0; m < 3; m++) begin
      set_nominal();
      intr = modes[m];
      build_exp();
      start = 1'b1;
      capture(1'b1, gap, to, ok);
      vecs++;
      if (to || got_d.size() != ncol[m]) begin
        errs++;
        $display("FAIL variant_%h cols: got %0d want %0d", modes[m], got_d.size(), ncol[m]);
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        vecs++;
        if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
          errs++;
          $display("FAIL variant_%h col%0d: got %h/%h want %h/%h",
                   modes[m], i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int gap;
    bit to, ok;
    for (int t = 0; t < 40; t++) begin
      set_random();
      build_exp();
      start = 1'b1;
      capture(1'b1, gap, to, ok);
      vecs++;
      if (to || gap != 2 || got_d.size() != exp_d.size()) begin
        errs++;
        $display("FAIL random%0d shape: got cols %0d gap %0d want cols %0d gap 2",
                 t, got_d.size(), gap, exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        vecs++;
        if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
          errs++;
          $display("FAIL random%0d col%0d: got %h/%h want %h/%h",
                   t, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
        end
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int gap, cyc, frames;
    bit to, ok;
    set_random();
    intr = 8'h00;
    build_exp();
    start = 1'b1;
    cyc = 0;
    frames = 0;
    to = 1'b0;
    while (cyc < 2000 && !to) begin
      capture(1'b0, gap, to, ok);
      cyc += gap + got_d.size();
      vecs++;
      if (to || gap < 2 || !ok) begin
        errs++;
        $display("FAIL b2b%0d gap: got %0d idle_ok %0b want >=2 idle 1", frames, gap, ok);
      end
      vecs++;
      if (got_d.size() != exp_d.size()) begin
        errs++;
        $display("FAIL b2b%0d cols: got %0d want %0d", frames, got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        vecs++;
        if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
          errs++;
          $display("FAIL b2b%0d col%0d: got %h/%h want %h/%h",
                   frames, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
        end
      end
      frames++;
    end
    start = 1'b0;
    vecs++;
    if (frames < 100) begin errs++; $display("FAIL b2b_count: got %0d want >=100", frames); end
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txv !== 1'b0) ok = 1'b0;
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL b2b_stop: got frame after start low want idle"); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    set_nominal();
    start = 1'b1;
    repeat (4) @(negedge clk);
    vecs++;
    if (txv !== 1'b1) begin errs++; $display("FAIL mid_active: got %b want 1", txv); end
    #2 rst_n = 1'b0;
    #1;
    start = 1'b0;
    vecs++;
    if (mdata !== IDLE_COL || mvalid !== 8'hFF || txv !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: got %h/%h/%b want %h/ff/0", mdata, mvalid, txv, IDLE_COL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (txv !== 1'b0 || mdata !== IDLE_COL || mvalid !== 8'hFF) ok = 1'b0;
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL mid_after: got activity want idle"); end
  endtask

  initial begin
    set_nominal();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_nominal();
    test_variants();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
